bram_responder: RTL

- Dual-port, word-organised on-chip memory model that acts as the responder for the BRAM_PORTA/BRAM_PORTB master interfaces driven by our PE accelerator tops.
- Accepts byte addresses, byte write-enables and port enables, and returns registered read data.
- Flags cross-port collisions and out-of-range accesses, and counts accesses for debug and verification.
- Sits between a PE top and the host-loaded buffer, standing in for an AXI BRAM controller + block RAM pair in simulation and standalone FPGA tests.

---
 rtl/bram_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/bram_responder.sv
// bram_responder: dual-port, word-organised memory model that answers the
// BRAM_PORTA / BRAM_PORTB master interfaces of the PE accelerator tops.
//
// Ports
//   clk, rst                 single clock, asynchronous active-high reset
//   ena/addra/dina/wea       port A enable, byte address, write data, byte enables
//   douta                    port A registered read data (read-first)
//   enb/addrb/dinb/web       port B, same as port A
//   doutb                    port B registered read data (read-first)
//   clr                      synchronous clear of flags and counters
//   collision                sticky: both ports hit one word in one cycle with a write
//   range_err                sticky: enabled access out of range or misaligned
//   rd_cnt / wr_cnt          saturating access counters, both ports summed
//
// Optional build macro BRAM_RESPONDER_OUTREG_EN adds a second output register
// per port (read latency 2). Flags and counters keep their 1-cycle timing.
module bram_responder #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [31:0]      addra,
  input  logic [31:0]      dina,
  input  logic [3:0]       wea,
  output logic [31:0]      douta,
  input  logic             enb,
  input  logic [31:0]      addrb,
  input  logic [31:0]      dinb,
  input  logic [3:0]       web,
  output logic [31:0]      doutb,
  input  logic             clr,
  output logic             collision,
  output logic             range_err,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);

  logic [31:0] mem_q [DEPTH];

  logic [AW-1:0] idx_a, idx_b;
  logic          inr_a, inr_b;

  assign idx_a = addra[AW+1:2];
  assign idx_b = addrb[AW+1:2];
  assign inr_a = (addra[31:AW+2] == '0) && (addra[1:0] == 2'b00);
  assign inr_b = (addrb[31:AW+2] == '0) && (addrb[1:0] == 2'b00);

  // Port B is written after port A so B wins a shared byte lane.
  always_ff @(posedge clk) begin
    if (ena && inr_a) begin
      for (int i = 0; i < 4; i++) begin
        if (wea[i]) mem_q[idx_a][8*i +: 8] <= dina[8*i +: 8];
      end
    end
    if (enb && inr_b) begin
      for (int i = 0; i < 4; i++) begin
        if (web[i]) mem_q[idx_b][8*i +: 8] <= dinb[8*i +: 8];
      end
    end
  end

  logic [31:0]      rd_a_d, rd_a_q, rd_b_d, rd_b_q;
  logic             collision_d, collision_q, range_err_d, range_err_q;
  logic [CNT_W-1:0] rd_cnt_d, rd_cnt_q, wr_cnt_d, wr_cnt_q;
  logic             coll_hit, rerr_hit;
  logic [1:0]       rd_inc, wr_inc;
  logic [CNT_W:0]   rd_sum, wr_sum;

  always_comb begin
    // Reads sample the array before this edge's writes land: read-first.
    rd_a_d = rd_a_q;
    rd_b_d = rd_b_q;
    if (ena) rd_a_d = inr_a ? mem_q[idx_a] : '0;
    if (enb) rd_b_d = inr_b ? mem_q[idx_b] : '0;

    coll_hit = ena && enb && inr_a && inr_b && (idx_a == idx_b) &&
               ((wea != 4'b0) || (web != 4'b0));
    rerr_hit = (ena && !inr_a) || (enb && !inr_b);

    rd_inc = {1'b0, ena && (wea == 4'b0)} + {1'b0, enb && (web == 4'b0)};
    wr_inc = {1'b0, ena && (wea != 4'b0)} + {1'b0, enb && (web != 4'b0)};
    rd_sum = {1'b0, rd_cnt_q} + {{(CNT_W-1){1'b0}}, rd_inc};
    wr_sum = {1'b0, wr_cnt_q} + {{(CNT_W-1){1'b0}}, wr_inc};

    collision_d = collision_q | coll_hit;
    range_err_d = range_err_q | rerr_hit;
    // Carry out of the widened sum means the counter would pass all-ones.
    rd_cnt_d    = rd_sum[CNT_W] ? '1 : rd_sum[CNT_W-1:0];
    wr_cnt_d    = wr_sum[CNT_W] ? '1 : wr_sum[CNT_W-1:0];

    if (clr) begin
      collision_d = 1'b0;
      range_err_d = 1'b0;
      rd_cnt_d    = '0;
      wr_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_a_q      <= '0;
      rd_b_q      <= '0;
      collision_q <= 1'b0;
      range_err_q <= 1'b0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
    end else begin
      rd_a_q      <= rd_a_d;
      rd_b_q      <= rd_b_d;
      collision_q <= collision_d;
      range_err_q <= range_err_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

`ifdef BRAM_RESPONDER_OUTREG_EN
  // Stage 2 only advances when stage 1 took a fresh read on the previous edge.
  logic        vld_a_q, vld_b_q;
  logic [31:0] out_a_q, out_b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_a_q <= 1'b0;
      vld_b_q <= 1'b0;
      out_a_q <= '0;
      out_b_q <= '0;
    end else begin
      vld_a_q <= ena;
      vld_b_q <= enb;
      if (vld_a_q) out_a_q <= rd_a_q;
      if (vld_b_q) out_b_q <= rd_b_q;
    end
  end

  assign douta = out_a_q;
  assign doutb = out_b_q;
`else
  assign douta = rd_a_q;
  assign doutb = rd_b_q;
`endif

  assign collision = collision_q;
  assign range_err = range_err_q;
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;

endmodule
